// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtract per clock, borrow-out
// chooses between keeping the difference or restoring the shifted partial remainder.
module restoring_divider #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dvd_q;      // dividend shifting out MSB-first, quotient bits entering LSB
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH+1:0] sub;
    logic             borrow;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] dvd_d;

    // NOTE: every signal is given a value on every path, so no latch is inferred.
    always_comb begin
        p_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        sub     = {1'b0, p_shift} - {2'b00, dsr_q};
        borrow  = sub[WIDTH+1];
        rem_d   = borrow ? p_shift : sub[WIDTH:0];
        dvd_d   = {dvd_q[WIDTH-2:0], ~borrow};
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dvd_q   <= dividend;
                            dsr_q   <= divisor;
                            rem_q   <= '0;
                            count_q <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    dvd_q   <= dvd_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        quotient_q  <= dvd_d;
                        remainder_q <= rem_d[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: results, done latency, busy handshake,
// divide-by-zero, ignored mid-run starts, reset abort and back-to-back launches.
module tb_restoring_divider;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge, then operands are scrambled.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    // lat = number of edges after the accepting edge until done is visible.
    task automatic wait_done(output int lat);
        lat = 0;
        @(negedge clk);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        int               lat;
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        exp_q = (b == 0) ? '1 : a / b;
        exp_r = (b == 0) ? a : a % b;
        launch(a, b);
        wait_done(lat);
        check({tag, ".latency"}, lat, (b == 0) ? 0 : WIDTH);
        check({tag, ".quotient"}, quotient, exp_q);
        check({tag, ".remainder"}, remainder, exp_r);
        check({tag, ".dbz"}, div_by_zero, (b == 0) ? 1 : 0);
        check({tag, ".busy_in_done"}, busy, 1);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".busy_idle"}, busy, 0);
        check({tag, ".q_held"}, quotient, exp_q);
    endtask

    initial begin
        int first_done;
        int second_done;
        int pulses;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.quotient", quotient, 0);
        check("reset.remainder", remainder, 0);
        check("reset.dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(10'd1000, 10'd7, "t1_1000_7");
        run_div(10'd1023, 10'd1, "t2_1023_1");
        run_div(10'd5, 10'd9, "t2_5_9");
        run_div(10'd0, 10'd3, "t2_0_3");
        run_div(10'd500, 10'd0, "t3_500_0");
        run_div(10'd1023, 10'd1023, "edge_eq");
        run_div(10'd1022, 10'd1023, "edge_lt");

        // A start pulse three cycles into RUN must be ignored.
        launch(10'd900, 10'd30);
        first_done = -1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b1;
                dividend = 10'd1;
                divisor = 10'd1;
            end
            if (i == 3) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = i;
            end
        end
        check("t4.done_index", first_done, WIDTH);
        check("t4.pulses", pulses, 1);
        check("t4.quotient", quotient, 30);
        check("t4.remainder", remainder, 0);

        // Reset mid-RUN aborts the divide.
        launch(10'd777, 10'd5);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5.busy", busy, 0);
        check("t5.done", done, 0);
        check("t5.quotient", quotient, 0);
        check("t5.remainder", remainder, 0);
        check("t5.dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("t5.no_done", pulses, 0);
        run_div(10'd999, 10'd10, "t5_999_10");

        // Start held high relaunches on the IDLE cycle after DONE.
        start = 1'b1;
        dividend = 10'd100;
        divisor = 10'd7;
        first_done = -1;
        second_done = -1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i == 11) check("hold.busy_idle", busy, 0);
            if (i == 12) begin
                check("hold.busy_relaunch", busy, 1);
                start = 1'b0;
            end
            if (done === 1'b1) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        check("hold.first_done", first_done, WIDTH);
        check("hold.second_done", second_done, 2 * WIDTH + 2);
        check("hold.quotient", quotient, 14);
        check("hold.remainder", remainder, 2);

        // Back-to-back pseudo-random operands.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom_range(1023, 0));
            rb = WIDTH'($urandom_range(1023, 1));
            run_div(ra, rb, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
